// File: rtl/axi_bram_log_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_bram_log_reader_if
//  Description : Signal bundle for axi_bram_log_reader. It carries the readout
//                control inputs, the BRAM read port and the decoded entry
//                stream.
//                  master : host / BRAM side (drives Start, Clear, counts,
//                           BRAM read data, Ready)
//                  slave  : the reader (drives BRAM enable/address, decoded
//                           entry, Valid, Busy, Done)
//                Macro AXI_BRAM_LOG_READER_ID_FILTER_EN adds IdMatch_DI and
//                IdMask_DI.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_bram_log_reader_if #(
   parameter int AXI_ID_BITW     = 8,
   parameter int AXI_ADDR_BITW   = 32,
   parameter int NUM_LOG_ENTRIES = 16384,
   parameter int AXI_LEN_BITW    = 8
);
   localparam int c_WORDS         = (AXI_ADDR_BITW == 64) ? 4 : 3;
   localparam int c_BRAM_ADDR_BITW = $clog2(NUM_LOG_ENTRIES * c_WORDS);
   localparam int c_CNT_BITW      = $clog2(NUM_LOG_ENTRIES + 1);

   logic                        Start_SI;
   logic                        Clear_SI;
   logic [c_CNT_BITW-1:0]       NumEntries_DI;
`ifdef AXI_BRAM_LOG_READER_ID_FILTER_EN
   logic [AXI_ID_BITW-1:0]      IdMatch_DI;
   logic [AXI_ID_BITW-1:0]      IdMask_DI;
`endif
   logic                        BramEn_SO;
   logic [c_BRAM_ADDR_BITW-1:0] BramAddr_DO;
   logic [31:0]                 BramRd_DI;
   logic                        Valid_SO;
   logic                        Ready_SI;
   logic [31:0]                 Timestamp_DO;
   logic [AXI_LEN_BITW-1:0]     Len_DO;
   logic [AXI_ID_BITW-1:0]      Id_DO;
   logic [AXI_ADDR_BITW-1:0]    Addr_DO;
   logic                        Busy_SO;
   logic                        Done_SO;

   modport master (
      output Start_SI, Clear_SI, NumEntries_DI, BramRd_DI, Ready_SI,
`ifdef AXI_BRAM_LOG_READER_ID_FILTER_EN
      output IdMatch_DI, IdMask_DI,
`endif
      input  BramEn_SO, BramAddr_DO, Valid_SO, Timestamp_DO, Len_DO, Id_DO,
      input  Addr_DO, Busy_SO, Done_SO
   );

   modport slave (
      input  Start_SI, Clear_SI, NumEntries_DI, BramRd_DI, Ready_SI,
`ifdef AXI_BRAM_LOG_READER_ID_FILTER_EN
      input  IdMatch_DI, IdMask_DI,
`endif
      output BramEn_SO, BramAddr_DO, Valid_SO, Timestamp_DO, Len_DO, Id_DO,
      output Addr_DO, Busy_SO, Done_SO
   );
endinterface
`default_nettype wire

// File: rtl/axi_bram_log_reader.sv
`default_nettype none
// ============================================================================
//  Module      : axi_bram_log_reader
//  Description : Reads AXI access log entries back from the logger BRAM
//                (W = 3 or 4 32-bit words per entry), decodes timestamp,
//                ID, burst length and address, and offers each entry on a
//                valid/ready stream.
//  Ports       : Clk_CI  - clock
//                Rst_RI  - synchronous active-high reset
//                if_log  - axi_bram_log_reader_if.slave: Start/Clear/
//                          NumEntries control, BRAM read port (En/Addr/Rd),
//                          decoded entry stream (Valid/Ready + fields),
//                          Busy and Done status
//  Option      : `define AXI_BRAM_LOG_READER_ID_FILTER_EN to drop entries
//                whose masked ID differs from the masked match value.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_bram_log_reader #(
   parameter int AXI_ID_BITW     = 8,
   parameter int AXI_ADDR_BITW   = 32,
   parameter int NUM_LOG_ENTRIES = 16384,
   parameter int AXI_LEN_BITW    = 8
) (
   input  wire logic           Clk_CI,
   input  wire logic           Rst_RI,
   axi_bram_log_reader_if.slave if_log
);
   localparam int c_WORDS          = (AXI_ADDR_BITW == 64) ? 4 : 3;
   localparam int c_BRAM_ADDR_BITW = $clog2(NUM_LOG_ENTRIES * c_WORDS);
   localparam int c_CNT_BITW       = $clog2(NUM_LOG_ENTRIES + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_CAPTURE = 3'd2,
      S_OUTPUT  = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [c_CNT_BITW-1:0]       r_num;
   logic [c_CNT_BITW-1:0]       r_entry;
   logic [c_BRAM_ADDR_BITW-1:0] r_base;      // entry * W, kept incrementally
   logic [1:0]                  r_k;         // word index within the entry
   logic                        r_cap_vld;   // BRAM data valid this cycle
   logic [1:0]                  r_cap_k;     // which word that data is
   logic [31:0]                 r_ts;
   logic [AXI_LEN_BITW-1:0]     r_len;
   logic [AXI_ID_BITW-1:0]      r_id;
   logic [AXI_ADDR_BITW-1:0]    r_addr;

   logic                        w_start;
   logic                        w_advance;
   logic                        w_last;
   logic                        w_k_last;
   logic                        w_id_ok;
   logic                        w_cap;
   logic [c_CNT_BITW-1:0]       w_clamped;

   assign w_clamped = (if_log.NumEntries_DI > c_CNT_BITW'(NUM_LOG_ENTRIES)) ?
                      c_CNT_BITW'(NUM_LOG_ENTRIES) : if_log.NumEntries_DI;
   assign w_last    = (r_entry == (r_num - c_CNT_BITW'(1)));
   assign w_k_last  = (r_k == 2'(c_WORDS - 1));
   // Capture is blocked once Clear lands so the data outputs keep the
   // value they had when the readout was aborted.
   assign w_cap     = r_cap_vld && !if_log.Clear_SI;

`ifdef AXI_BRAM_LOG_READER_ID_FILTER_EN
   logic [AXI_ID_BITW-1:0] r_match;
   logic [AXI_ID_BITW-1:0] r_mask;

   // The meta word is captured before CAPTURE, so r_id is already the
   // current entry's ID when the skip decision is made.
   assign w_id_ok = ((r_id & r_mask) == (r_match & r_mask));

   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         r_match <= '0;
         r_mask  <= '0;
      end else if (w_start) begin
         r_match <= if_log.IdMatch_DI;
         r_mask  <= if_log.IdMask_DI;
      end
   end
`else
   assign w_id_ok = 1'b1;
`endif

   // ---------------------------------------------------------------- FSM
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_advance   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (if_log.Start_SI) begin
               w_start     = 1'b1;
               w_state_nxt = (w_clamped == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            if (w_k_last) begin
               w_state_nxt = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (!w_id_ok) begin
               if (w_last) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_FETCH;
                  w_advance   = 1'b1;
               end
            end else begin
               w_state_nxt = S_OUTPUT;
            end
         end
         S_OUTPUT: begin
            if (if_log.Ready_SI) begin
               if (w_last) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_FETCH;
                  w_advance   = 1'b1;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      // Abort wins over start and handshake.
      if (if_log.Clear_SI) begin
         w_state_nxt = S_IDLE;
         w_start     = 1'b0;
         w_advance   = 1'b0;
      end
   end

   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         r_state   <= S_IDLE;
         r_num     <= '0;
         r_entry   <= '0;
         r_base    <= '0;
         r_k       <= '0;
         r_cap_vld <= 1'b0;
         r_cap_k   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cap_vld <= (r_state == S_FETCH) && !if_log.Clear_SI;
         r_cap_k   <= r_k;
         if (w_start) begin
            r_num   <= w_clamped;
            r_entry <= '0;
            r_base  <= '0;
            r_k     <= '0;
         end else if (w_advance) begin
            r_entry <= r_entry + c_CNT_BITW'(1);
            r_base  <= r_base + c_BRAM_ADDR_BITW'(c_WORDS);
            r_k     <= '0;
         end else if (r_state == S_FETCH) begin
            r_k     <= w_k_last ? 2'd0 : (r_k + 2'd1);
         end
      end
   end

   // ---------------------------------------------------------- decode
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         r_ts  <= '0;
         r_len <= '0;
         r_id  <= '0;
      end else if (w_cap) begin
         if (r_cap_k == 2'd0) begin
            r_ts <= if_log.BramRd_DI;
         end
         if (r_cap_k == 2'd1) begin
            r_len <= if_log.BramRd_DI[AXI_LEN_BITW-1:0];
            r_id  <= if_log.BramRd_DI[AXI_LEN_BITW+AXI_ID_BITW-1:AXI_LEN_BITW];
         end
      end
   end

   generate
      if (AXI_ADDR_BITW == 64) begin : g_addr64
         always_ff @(posedge Clk_CI) begin
            if (Rst_RI) begin
               r_addr <= '0;
            end else if (w_cap) begin
               if (r_cap_k == 2'd2) begin
                  r_addr[31:0] <= if_log.BramRd_DI;
               end
               if (r_cap_k == 2'd3) begin
                  r_addr[AXI_ADDR_BITW-1:32] <= if_log.BramRd_DI;
               end
            end
         end
      end else begin : g_addr32
         always_ff @(posedge Clk_CI) begin
            if (Rst_RI) begin
               r_addr <= '0;
            end else if (w_cap && (r_cap_k == 2'd2)) begin
               r_addr <= if_log.BramRd_DI;
            end
         end
      end
   endgenerate

   // --------------------------------------------------------- outputs
   assign if_log.BramEn_SO    = (r_state == S_FETCH);
   assign if_log.BramAddr_DO  = r_base + c_BRAM_ADDR_BITW'(r_k);
   assign if_log.Valid_SO     = (r_state == S_OUTPUT);
   assign if_log.Busy_SO      = (r_state != S_IDLE);
   assign if_log.Done_SO      = (r_state == S_DONE);
   assign if_log.Timestamp_DO = r_ts;
   assign if_log.Len_DO       = r_len;
   assign if_log.Id_DO        = r_id;
   assign if_log.Addr_DO      = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_axi_bram_log_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_bram_log_reader
//  Description : Self-checking bench for axi_bram_log_reader. A BRAM model
//                with one-cycle read latency feeds the DUT; expected entries
//                are taken straight from the BRAM contents by entry index.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_bram_log_reader;
   localparam int ID_W   = 8;
   localparam int ADDR_W = 32;
   localparam int N      = 8;
   localparam int LEN_W  = 8;
   localparam int W      = (ADDR_W == 64) ? 4 : 3;
   localparam int NW     = N * W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi_bram_log_reader_if #(
      .AXI_ID_BITW(ID_W), .AXI_ADDR_BITW(ADDR_W),
      .NUM_LOG_ENTRIES(N), .AXI_LEN_BITW(LEN_W)
   ) bus ();

   axi_bram_log_reader #(
      .AXI_ID_BITW(ID_W), .AXI_ADDR_BITW(ADDR_W),
      .NUM_LOG_ENTRIES(N), .AXI_LEN_BITW(LEN_W)
   ) dut (
      .Clk_CI(clk),
      .Rst_RI(rst),
      .if_log(bus)
   );

   logic [31:0] mem [NW];
   always @(posedge clk) begin
      if (bus.BramEn_SO) bus.BramRd_DI <= mem[bus.BramAddr_DO];
   end

   int n_cmp = 0;
   int n_mis = 0;
   int rise_q[$];
   int g_done_cyc;
   int g_last_addr;
`ifdef AXI_BRAM_LOG_READER_ID_FILTER_EN
   logic [ID_W-1:0] f_match = '0;
   logic [ID_W-1:0] f_mask  = '0;
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---- reference model: entry e lives in words e*W .. e*W+W-1
   function automatic logic [63:0] ref_ts(input int e);
      return 64'(mem[e*W]);
   endfunction
   function automatic logic [63:0] ref_len(input int e);
      return 64'(mem[e*W+1] % (1 << LEN_W));
   endfunction
   function automatic logic [63:0] ref_id(input int e);
      return 64'((mem[e*W+1] >> LEN_W) % (64'd1 << ID_W));
   endfunction
   function automatic logic [63:0] ref_addr(input int e);
      if (W == 4) return {mem[e*W+3], mem[e*W+2]};
      return 64'(mem[e*W+2]);
   endfunction
   function automatic bit ref_emit(input int e);
`ifdef AXI_BRAM_LOG_READER_ID_FILTER_EN
      logic [ID_W-1:0] id;
      id = ID_W'(ref_id(e));
      return ((id & f_mask) == (f_match & f_mask));
`else
      return (e >= 0);
`endif
   endfunction

   task automatic fill_random();
      for (int i = 0; i < NW; i++) mem[i] = $urandom;
   endtask

   task automatic start(input int n);
      bus.NumEntries_DI = 4'(n);
`ifdef AXI_BRAM_LOG_READER_ID_FILTER_EN
      bus.IdMatch_DI = f_match;
      bus.IdMask_DI  = f_mask;
`endif
      bus.Start_SI = 1'b1;
      tick();
      bus.Start_SI = 1'b0;
   endtask

   // Runs one readout after the Start edge. n = clamped entry count,
   // mode 0: Ready always 1, 1: random Ready, 2: Ready low for 7 valid cycles.
   task automatic drain(input int n, input int mode, input int budget);
      int  q[$];
      int  emitted = 0;
      int  fetch_i = 0;
      int  vrun    = 0;
      int  prev_e  = -1;
      bit  prev_hs = 0;
      bit  prev_v  = 0;
      bit  done    = 0;
      bit  rdy;
      rise_q.delete();
      g_done_cyc  = -1;
      g_last_addr = -1;
      for (int e = 0; e < n; e++) if (ref_emit(e)) q.push_back(e);
      for (int c = 0; c < budget && !done; c++) begin
         if (prev_hs) begin
            if (prev_e == n - 1) chk("done_after_last_hs", 64'(bus.Done_SO), 1);
            else                 chk("fetch_after_hs", 64'(bus.BramEn_SO), 1);
         end
         prev_hs = 0;
         if (bus.Valid_SO && !prev_v) rise_q.push_back(c);
         prev_v = bus.Valid_SO;
         if (bus.BramEn_SO) begin
            chk("bram_addr", 64'(bus.BramAddr_DO), 64'(fetch_i));
            g_last_addr = int'(bus.BramAddr_DO);
            fetch_i++;
         end
         if (bus.Valid_SO) begin
            chk("bram_en_in_output", 64'(bus.BramEn_SO), 0);
            if (emitted < q.size()) begin
               chk("timestamp", 64'(bus.Timestamp_DO), ref_ts(q[emitted]));
               chk("len",       64'(bus.Len_DO),       ref_len(q[emitted]));
               chk("id",        64'(bus.Id_DO),        ref_id(q[emitted]));
               chk("addr",      64'(bus.Addr_DO),      ref_addr(q[emitted]));
            end else begin
               chk("extra_valid", 64'(bus.Valid_SO), 0);
            end
            vrun++;
            case (mode)
               0:       rdy = 1'b1;
               1:       rdy = 1'($urandom_range(0, 1));
               default: rdy = (vrun >= 8);
            endcase
            bus.Ready_SI = rdy;
            if (rdy && emitted < q.size()) begin
               prev_hs = 1;
               prev_e  = q[emitted];
               emitted++;
               vrun    = 0;
            end
         end else begin
            bus.Ready_SI = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 0);
         end
         if (bus.Done_SO) begin
            g_done_cyc = c;
            chk("entries_emitted", 64'(emitted), 64'(q.size()));
            chk("words_fetched",   64'(fetch_i), 64'(n * W));
            chk("busy_in_done",    64'(bus.Busy_SO), 1);
            done = 1;
         end else begin
            chk("busy_while_active", 64'(bus.Busy_SO), 1);
         end
         tick();
      end
      chk("drain_finished", 64'(done), 1);
      if (done) begin
         chk("done_one_cycle", 64'(bus.Done_SO), 0);
         chk("idle_after_done", 64'(bus.Busy_SO), 0);
      end
      bus.Ready_SI = 1'b0;
   endtask

   initial begin
      int  cnt;
      bit  found;
      bus.Start_SI      = 1'b0;
      bus.Clear_SI      = 1'b0;
      bus.Ready_SI      = 1'b0;
      bus.NumEntries_DI = '0;
`ifdef AXI_BRAM_LOG_READER_ID_FILTER_EN
      bus.IdMatch_DI    = '0;
      bus.IdMask_DI     = '0;
`endif
      fill_random();

      // ---- reset state
      tick(); tick(); tick();
      chk("rst_valid", 64'(bus.Valid_SO), 0);
      chk("rst_busy",  64'(bus.Busy_SO), 0);
      chk("rst_done",  64'(bus.Done_SO), 0);
      chk("rst_en",    64'(bus.BramEn_SO), 0);
      chk("rst_baddr", 64'(bus.BramAddr_DO), 0);
      chk("rst_ts",    64'(bus.Timestamp_DO), 0);
      chk("rst_id",    64'(bus.Id_DO), 0);
      chk("rst_len",   64'(bus.Len_DO), 0);
      chk("rst_addr",  64'(bus.Addr_DO), 0);
      rst = 1'b0;
      tick();

      // ---- directed two-entry readout with Ready held high
      mem[0] = 32'h0000_0100; mem[1] = 32'h0000_0507; mem[2] = 32'h8000_1000;
      mem[3] = 32'h0000_0200; mem[4] = 32'h0000_0A00; mem[5] = 32'h8000_2000;
      start(2);
      drain(2, 0, 100);
      chk("valid_rise_count", 64'(rise_q.size()), 2);
      if (rise_q.size() == 2) begin
         chk("first_valid_edge",  64'(rise_q[0]), 64'(W + 1));
         chk("second_valid_edge", 64'(rise_q[1]), 64'(2 * W + 3));
      end
      chk("done_edge", 64'(g_done_cyc), 64'(2 * W + 4));

      // ---- backpressure: Ready low for 7 valid cycles per entry
      fill_random();
      start(3);
      drain(3, 2, 200);

      // ---- zero entries: Done right after Start, nothing fetched
      start(0);
      drain(0, 0, 20);
      chk("zero_done_edge", 64'(g_done_cyc), 0);
      chk("zero_no_valid", 64'(rise_q.size()), 0);

      // ---- clamp above capacity
      fill_random();
      start(N + 5);
      drain(N, 1, 2000);
      chk("clamp_last_addr", 64'(g_last_addr), 64'(NW - 1));

      // ---- random readouts
      for (int r = 0; r < 3; r++) begin
         int n;
         fill_random();
         n = $urandom_range(1, N);
         start(n);
         drain(n, 1, 2000);
      end

      // ---- Clear during OUTPUT of entry 3, then restart
      fill_random();
      start(6);
      bus.Ready_SI = 1'b1;
      cnt   = 0;
      found = 0;
      for (int c = 0; c < 200 && !found; c++) begin
         if (bus.Valid_SO) begin
            if (cnt == 3) found = 1;
            else cnt++;
         end
         if (!found) tick();
      end
      chk("clear_reached_entry3", 64'(found), 1);
      bus.Clear_SI = 1'b1;
      tick();
      bus.Clear_SI = 1'b0;
      bus.Ready_SI = 1'b0;
      chk("clear_valid", 64'(bus.Valid_SO), 0);
      chk("clear_en",    64'(bus.BramEn_SO), 0);
      chk("clear_busy",  64'(bus.Busy_SO), 0);
      chk("clear_done",  64'(bus.Done_SO), 0);
      chk("clear_hold_ts", 64'(bus.Timestamp_DO), ref_ts(3));
      tick();
      chk("clear_no_done_later", 64'(bus.Done_SO), 0);
      chk("clear_idle_later",    64'(bus.Busy_SO), 0);
      start(1);
      drain(1, 0, 100);

      // ---- reset mid-operation zeroes everything
      fill_random();
      start(4);
      for (int i = 0; i < W + 2; i++) tick();
      rst = 1'b1;
      tick();
      chk("midrst_busy",  64'(bus.Busy_SO), 0);
      chk("midrst_valid", 64'(bus.Valid_SO), 0);
      chk("midrst_ts",    64'(bus.Timestamp_DO), 0);
      chk("midrst_addr",  64'(bus.Addr_DO), 0);
      rst = 1'b0;
      tick();

`ifdef AXI_BRAM_LOG_READER_ID_FILTER_EN
      // ---- ID filter: ids {05, 0A, 05}, match 05 under full mask
      fill_random();
      mem[1] = 32'h0000_0503; mem[4] = 32'h0000_0A01; mem[7] = 32'h0000_0509;
      f_match = 8'h05;
      f_mask  = 8'hFF;
      start(3);
      drain(3, 0, 100);
      chk("filter_valid_count", 64'(rise_q.size()), 2);
      // random filter run
      fill_random();
      f_match = ID_W'($urandom);
      f_mask  = ID_W'($urandom_range(0, 3));
      start(N);
      drain(N, 1, 2000);
      f_match = '0;
      f_mask  = '0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "global timeout");
   end
endmodule
`default_nettype wire
